// File: rtl/config_word_serializer.sv
// Serializes host config words MSB-first into the CGRA scan chain; word_ready depends on state only.
// Optional CRC-16-CCITT check of the shifted stream under `CONFIG_SERIALIZER_CRC_EN.
module config_word_serializer #(
  parameter int WORD_W     = 32,
  parameter int TOTAL_BITS = 1024,
  parameter int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_bit,
  output logic              config_clock_en,
  output logic              config_reset,
  output logic              busy,
  output logic              done
`ifdef CONFIG_SERIALIZER_CRC_EN
  ,
  input  logic [15:0]       expected_crc,
  output logic              crc_err
`endif
);

  localparam int WB_W  = $clog2(WORD_W + 1);
  localparam int CMP_W = (CNT_W > WB_W) ? CNT_W : WB_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAIN_RST,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_bits_left;
  logic [WB_W-1:0]   r_word_bits;
  logic              w_accept;
  logic              w_start_ok;
  logic              w_last_word;
  logic [WB_W-1:0]   w_load_bits;

  assign w_accept    = (r_state == S_LOAD) && word_valid;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // A short final word only shifts its upper bits_left MSBs.
  assign w_last_word = CMP_W'(r_bits_left) < CMP_W'(WORD_W);
  assign w_load_bits = w_last_word ? WB_W'(r_bits_left) : WB_W'(WORD_W);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    word_ready      = 1'b0;
    config_bit      = 1'b0;
    config_clock_en = 1'b0;
    config_reset    = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CHAIN_RST;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_CHAIN_RST;
      end
      S_CHAIN_RST: begin
        config_reset = 1'b1;
        busy         = 1'b1;
        w_next       = S_LOAD;
      end
      S_LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy            = 1'b1;
        config_clock_en = 1'b1;
        config_bit      = r_sreg[WORD_W-1];
        if (r_word_bits == WB_W'(1)) begin
          w_next = (r_bits_left == CNT_W'(1)) ? S_DONE : S_LOAD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg      <= '0;
      r_bits_left <= '0;
      r_word_bits <= '0;
    end else if (w_start_ok) begin
      r_bits_left <= CNT_W'(TOTAL_BITS);
    end else if (w_accept) begin
      r_sreg      <= word_data;
      r_word_bits <= w_load_bits;
    end else if (r_state == S_SHIFT) begin
      r_sreg      <= {r_sreg[WORD_W-2:0], 1'b0};
      r_word_bits <= r_word_bits - WB_W'(1);
      r_bits_left <= r_bits_left - CNT_W'(1);
    end
  end

`ifdef CONFIG_SERIALIZER_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_next;
  logic        w_fb;

  assign w_fb       = r_crc[15] ^ r_sreg[WORD_W-1];
  assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

  // The verdict folds in the last bit, which is still being shifted on the DONE-entry edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc   <= 16'hFFFF;
      crc_err <= 1'b0;
    end else begin
      if (r_state == S_CHAIN_RST) begin
        r_crc <= 16'hFFFF;
      end else if (r_state == S_SHIFT) begin
        r_crc <= w_crc_next;
      end
      if (w_start_ok) begin
        crc_err <= 1'b0;
      end else if ((r_state == S_SHIFT) && (w_next == S_DONE)) begin
        crc_err <= (w_crc_next != expected_crc);
      end
    end
  end
`endif

endmodule

// File: tb/tb_config_word_serializer.sv
// Directed + randomized bench for config_word_serializer; the expected stream is the concatenation of host words.
module tb_config_word_serializer;
  localparam int WW = 32;
  localparam int TB = 70;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, start, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, config_bit, config_clock_en, config_reset, busy, done;
  logic          s_start, s_word_valid;
  logic [WW-1:0] s_word_data;
  logic          s_word_ready, s_config_bit, s_config_clock_en, s_config_reset, s_busy, s_done;
`ifdef CONFIG_SERIALIZER_CRC_EN
  logic [15:0]   expected_crc, s_expected_crc;
  logic          crc_err, s_crc_err;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [WW-1:0] words[$];
  int            gaps[$];
  bit            exp_bits[$];
  bit            got_bits[$];

  config_word_serializer #(.WORD_W(WW), .TOTAL_BITS(TB)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .config_bit(config_bit), .config_clock_en(config_clock_en),
    .config_reset(config_reset), .busy(busy), .done(done)
`ifdef CONFIG_SERIALIZER_CRC_EN
    , .expected_crc(expected_crc), .crc_err(crc_err)
`endif
  );

  config_word_serializer #(.WORD_W(WW), .TOTAL_BITS(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(s_start),
    .word_data(s_word_data), .word_valid(s_word_valid), .word_ready(s_word_ready),
    .config_bit(s_config_bit), .config_clock_en(s_config_clock_en),
    .config_reset(s_config_reset), .busy(s_busy), .done(s_done)
`ifdef CONFIG_SERIALIZER_CRC_EN
    , .expected_crc(s_expected_crc), .crc_err(s_crc_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected chain contents: host words laid end to end, MSB first, truncated to the chain length.
  task automatic build_expected(input int total);
    logic [WW-1:0] w;
    exp_bits.delete();
    for (int i = 0; i < total; i++) begin
      w = words[i / WW];
      exp_bits.push_back(w[WW-1-(i % WW)]);
    end
  endtask

  function automatic int count_mismatch();
    int n = 0;
    for (int i = 0; i < exp_bits.size(); i++) begin
      if (i >= got_bits.size() || got_bits[i] != exp_bits[i]) n++;
    end
    return n;
  endfunction

`ifdef CONFIG_SERIALIZER_CRC_EN
  function automatic logic [15:0] model_crc();
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < exp_bits.size(); i++) begin
      if (c[15] ^ exp_bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // One full pass on the 70-bit DUT; e counts rising edges after the edge that sampled start.
  task automatic run_pass(input string tag, input int start_at, output int done_e);
    int e, wi, stall, stalls, bad;
    build_expected(TB);
    got_bits.delete();
    @(negedge clock); start = 1'b1; word_valid = 1'b0;
    @(negedge clock); start = 1'b0;
    check($sformatf("%s chain_rst", tag), {config_reset, config_clock_en, busy, word_ready}, 4'b1010);
    e = 0; wi = 0; stall = 0; stalls = 0; bad = 0; done_e = -1;
    while (e < 600) begin
      if (done) begin
        done_e = e;
        break;
      end
      if (config_clock_en) got_bits.push_back(config_bit);
      else if (config_bit) bad++;
      if (config_clock_en && (word_ready || config_reset)) bad++;
      if (config_reset && e != 0) bad++;
      word_valid = 1'b0;
      start = (e == start_at);
      if (word_ready && wi < words.size()) begin
        if (stall < gaps[wi]) begin
          stall++;
          stalls++;
        end else begin
          word_valid = 1'b1;
          word_data  = words[wi];
          wi++;
          stall = 0;
        end
      end
      @(negedge clock);
      e++;
    end
    start = 1'b0; word_valid = 1'b0;
    check($sformatf("%s done_latency", tag), done_e, 1 + words.size() + TB + stalls);
    check($sformatf("%s bit_count", tag), got_bits.size(), TB);
    check($sformatf("%s stream_mismatches", tag), count_mismatch(), 0);
    check($sformatf("%s gating_violations", tag), bad, 0);
    check($sformatf("%s done_outputs", tag), {busy, word_ready, config_clock_en, config_bit}, 4'b0000);
  endtask

  initial begin
    int de, e, rdy, ready_seen;
    logic [WW-1:0] got32;
    reset_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
    s_start = 1'b0; s_word_valid = 1'b0; s_word_data = '0;
`ifdef CONFIG_SERIALIZER_CRC_EN
    expected_crc = 16'h0000; s_expected_crc = 16'h0000;
`endif
    repeat (2) @(negedge clock);
    check("reset_outputs", {word_ready, config_bit, config_clock_en, config_reset, busy, done}, 6'b0);
    check("reset_outputs32", {s_word_ready, s_config_clock_en, s_config_reset, s_busy, s_done}, 5'b0);
    reset_n = 1'b1;

    // Scenario 1: async reset in the middle of SHIFT.
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; word_valid = 1'b1; word_data = 32'hFFFF_FFFF;
    repeat (6) @(negedge clock);
    word_valid = 1'b0;
    check("s1 in_shift", {config_clock_en, busy, config_bit}, 3'b111);
    #2 reset_n = 1'b0;
    #1 check("s1 async_reset", {word_ready, config_bit, config_clock_en, config_reset, busy, done}, 6'b0);
    @(negedge clock); reset_n = 1'b1;

    // Scenario 2: three always-valid words.
    words = '{32'h8000_0001, 32'hFFFF_0000, 32'hA800_0000};
    gaps  = '{0, 0, 0};
    run_pass("s2", -1, de);
    check("s2 latency_74", de, 74);

    // Scenario 3: five-cycle host stall before word 2.
    gaps = '{0, 5, 0};
    run_pass("s3", -1, de);
    check("s3 latency_79", de, 79);

    // Scenario 4: start during SHIFT is ignored; a word offered in DONE is refused.
    gaps = '{0, 0, 0};
    run_pass("s4", 20, de);
    word_valid = 1'b1; word_data = 32'h1234_5678;
    ready_seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (word_ready || !done) ready_seen++;
    end
    word_valid = 1'b0;
    check("s4 done_refuses_word", ready_seen, 0);

    // Randomized passes: random words and random host stalls.
    for (int p = 0; p < 3; p++) begin
      words = '{$urandom, $urandom, $urandom};
      gaps  = '{$urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6)};
      run_pass($sformatf("rand%0d", p), -1, de);
    end

`ifdef CONFIG_SERIALIZER_CRC_EN
    // Scenario 6: CRC verdict with a correct and a corrupted reference.
    words = '{32'h8000_0001, 32'hFFFF_0000, 32'hA800_0000};
    gaps  = '{0, 0, 0};
    build_expected(TB);
    expected_crc = model_crc();
    run_pass("s6a", -1, de);
    check("s6a crc_err", {crc_err, done}, 2'b01);
    expected_crc = model_crc() ^ 16'h0008;
    run_pass("s6b", -1, de);
    check("s6b crc_err", {crc_err, done}, 2'b11);
`endif

    // Scenario 5: 32-bit chain, single word.
    words = '{32'hDEAD_BEEF};
    build_expected(32);
`ifdef CONFIG_SERIALIZER_CRC_EN
    s_expected_crc = model_crc();
`endif
    got_bits.delete();
    @(negedge clock); s_start = 1'b1;
    @(negedge clock); s_start = 1'b0;
    check("s5 chain_rst", {s_config_reset, s_busy}, 2'b11);
    e = -1; rdy = 0;
    for (int k = 0; k < 200; k++) begin
      if (s_done) begin
        e = k;
        break;
      end
      if (s_config_clock_en) got_bits.push_back(s_config_bit);
      if (s_word_ready) begin
        rdy++;
        s_word_valid = 1'b1;
        s_word_data  = 32'hDEAD_BEEF;
      end else begin
        s_word_valid = 1'b0;
      end
      @(negedge clock);
    end
    s_word_valid = 1'b0;
    got32 = '0;
    for (int i = 0; i < got_bits.size() && i < 32; i++) got32[31-i] = got_bits[i];
    check("s5 latency", e, 34);
    check("s5 load_count", rdy, 1);
    check("s5 bit_count", got_bits.size(), 32);
    check("s5 stream", got32, 32'hDEAD_BEEF);
    check("s5 done_outputs", {s_busy, s_word_ready, s_config_clock_en}, 3'b000);
`ifdef CONFIG_SERIALIZER_CRC_EN
    check("s5 crc_err", s_crc_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
